// File: rtl/ex_div_ctrl.sv
// Multi-cycle restoring divide sequencer for the EX stage (DIV/DIVU).
// One quotient bit per cycle; stalls the pipeline until the result is ready.
module ex_div_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                div_start_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BYZERO, ST_ON, ST_END} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            state_r, state_nxt;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] rem_r;    // partial remainder
  logic [DATA_W-1:0] quo_r;    // dividend bits shifting out, quotient bits shifting in
  logic [DATA_W-1:0] dvs_r;    // |divisor|
  logic              neg_q_r;  // negate quotient at the end
  logic              neg_r_r;  // negate remainder at the end

  logic [DATA_W:0]   shifted, trial;
  logic [DATA_W-1:0] rem_nxt, quo_nxt, q_fix, r_fix;
  logic [DATA_W-1:0] abs1, abs2;

  assign stallreq_o = div_start_i & ~ready_o;

  // Operand magnitudes for the unsigned core.
  always_comb begin
    abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  end

  // One restoring step plus the final sign correction.
  always_comb begin
    shifted = {rem_r, quo_r[DATA_W-1]};
    trial   = shifted - {1'b0, dvs_r};
    if (!trial[DATA_W]) begin
      rem_nxt = trial[DATA_W-1:0];
      quo_nxt = {quo_r[DATA_W-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[DATA_W-1:0];
      quo_nxt = {quo_r[DATA_W-2:0], 1'b0};
    end
    q_fix = neg_q_r ? -quo_nxt : quo_nxt;
    r_fix = neg_r_r ? -rem_nxt : rem_nxt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt;
  end

  // Next-state logic; annul beats start everywhere.
  always_comb begin
    state_nxt = state_r;
    if (annul_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   if (div_start_i) state_nxt = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
        ST_BYZERO: state_nxt = ST_END;
        ST_ON:     if (cnt_r == LAST_CNT) state_nxt = ST_END;
        ST_END:    if (!div_start_i) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvs_r    <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else if (annul_i) begin
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (div_start_i && opdata2_i != '0) begin
            rem_r   <= '0;
            quo_r   <= abs1;
            dvs_r   <= abs2;
            neg_q_r <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r_r <= signed_div_i & opdata1_i[DATA_W-1];
            cnt_r   <= '0;
          end
        end
        ST_BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        ST_ON: begin
          rem_r <= rem_nxt;
          quo_r <= quo_nxt;
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == LAST_CNT) begin
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
          end
        end
        ST_END: begin
          if (!div_start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Randomized self-checking bench for ex_div_ctrl against an arithmetic reference.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ex_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_start_i  (div_start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // {remainder, quotient} from plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (!sg) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  // Full operation: start, latency, result, hold, release.
  task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
    int unsigned k;
    int unsigned lat;
    logic [63:0] exp;
    exp = ref_div(sg, a, b);
    lat = (b == 0) ? 2 : 33;
    @(negedge clk);
    div_start_i  = 1'b1;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    #1 check("stall_at_start", {63'd0, stallreq_o}, 64'd1);
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      // operand changes after the start cycle must be ignored
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~sg;
      if (ready_o || k > 40) break;
      check("stall_busy", {63'd0, stallreq_o}, 64'd1);
    end
    check("latency", 64'(k), 64'(lat));
    check("result", result_o, exp);
    check("stall_done", {63'd0, stallreq_o}, 64'd0);
    repeat (2) @(negedge clk);
    check("hold_ready", {63'd0, ready_o}, 64'd1);
    check("hold_result", result_o, exp);
    div_start_i = 1'b0;
    @(negedge clk);
    check("release_ready", {63'd0, ready_o}, 64'd0);
    check("release_result", result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sg;
    int unsigned seen;
    rst_n = 1'b0; div_start_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    rst_n = 1'b1;

    // Directed corner cases.
    do_op(1'b0, 32'd100, 32'd7);
    do_op(1'b1, -32'sd7, 32'd2);
    do_op(1'b1, 32'd7, -32'sd2);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    do_op(1'b1, $urandom, 32'd0);
    do_op(1'b0, 32'd0, 32'd0);

    // Annul mid-operation, start still high to prove annul priority.
    @(negedge clk);
    div_start_i = 1'b1; signed_div_i = 1'b0;
    opdata1_i = $urandom; opdata2_i = 32'd5;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; div_start_i = 1'b0;
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    check("annul_result", result_o, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    do_op(1'b0, 32'd9, 32'd3);

    // Reset mid-operation.
    @(negedge clk);
    div_start_i = 1'b1; signed_div_i = 1'b1;
    opdata1_i = $urandom; opdata2_i = 32'd3;
    repeat (21) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    div_start_i = 1'b0;
    rst_n = 1'b1;
    do_op(1'b0, 32'd1000, 32'd10);
    do_op(1'b1, -32'sd1000, 32'd10);

    // Randomized operations.
    for (int i = 0; i < 16; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(1, 15);
        1:       b = -$urandom_range(1, 15);
        2:       b = 32'd0;
        default: b = $urandom;
      endcase
      do_op(sg, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
